// File: rtl/aes_pkg.sv
// aes_pkg -- shared AES definitions for the iterative decryptor.
//   aes_state_e : FSM state encoding of aes_decrypt_iter
//   NUM_ROUNDS  : AES-128 round count
//   RCON        : round constants, indexed by round number 1..10 (index 0 and 11..15 unused)
//   SBOX        : forward S-box (key schedule)
//   INV_SBOX    : inverse S-box (InvSubBytes)
//   sub_word    : SubWord on a 32-bit word using the forward S-box
//   xtime       : GF(2^8) multiply by 2
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEXP  = 3'd1,
        ST_ADDK  = 3'd2,
        ST_ROUND = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } aes_state_e;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    // Padded to 16 entries so a 4-bit round counter can index it directly.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round -- one combinational inverse cipher round.
//   state_in  : current state, byte 0 in bits 127:120, column-major
//   round_key : round key added after InvSubBytes
//   last      : 1 skips InvMixColumns (final round)
//   state_out : InvMixColumns(InvSubBytes(InvShiftRows(state_in)) ^ round_key)
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] sub_st;
    logic [127:0] ark;
    logic [127:0] mix;

    function automatic logic [7:0] mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // Row r rotates right by r: output (r,c) takes input (r,(c-r) mod 4).
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            localparam int DST = 4 * c + r;
            assign sub_st[127-8*DST -: 8] = INV_SBOX[state_in[127-8*SRC -: 8]];
        end
    end

    assign ark = sub_st ^ round_key;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark[127-32*c -: 8];
        assign a1 = ark[119-32*c -: 8];
        assign a2 = ark[111-32*c -: 8];
        assign a3 = ark[103-32*c -: 8];
        assign mix[127-32*c -: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
        assign mix[119-32*c -: 8] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
        assign mix[111-32*c -: 8] = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
        assign mix[103-32*c -: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
    end

    assign state_out = last ? ark : mix;

endmodule

// File: rtl/key_expansion.sv
// key_expansion -- one forward AES-128 key-schedule step (combinational).
//   key_in  : round key K(r-1), word 0 in bits 127:96
//   rcon    : round constant for round r
//   key_out : round key K(r)
module key_expansion
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    // RotWord is a left byte rotation of the last word before SubWord.
    assign n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter -- iterative AES-128 decryptor, one round per clock,
// with a single-entry cache of the last expanded key's K10.
// All state changes on the falling edge of clk.
//   clk       : clock (falling edge active)
//   reset     : asynchronous active-low reset, clears everything incl. cache
//   in_valid  : ciphertext/key offered;  in_ready : high only in IDLE
//   data_in   : ciphertext;              key      : AES-128 cipher key
//   out_valid : plaintext available (DONE); out_ready : downstream accepts
//   plaintext : decrypted block, forced to 0 while out_valid is low
//   busy      : high in any state other than IDLE
module aes_decrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    aes_state_e   st;
    aes_state_e   nxt_st;
    logic [3:0]   rnd;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [127:0] key_q;
    logic [127:0] cache_key;
    logic [127:0] cache_k10;
    logic         cache_valid;

    logic         accept;
    logic         hit;
    logic [7:0]   rcon_cur;
    logic [127:0] fwd_key;
    logic [127:0] inv_key;
    logic [127:0] round_out;

    // Undo one key-schedule step: recover K(r-1) from K(r) using Rcon_r.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0]   ^ k[63:32];
        n2 = k[63:32]  ^ k[95:64];
        n1 = k[95:64]  ^ k[127:96];
        n0 = k[127:96] ^ sub_word({n3[23:0], n3[31:24]}) ^ {rc, 24'h000000};
        return {n0, n1, n2, n3};
    endfunction

    assign accept   = in_valid && (st == ST_IDLE);
    assign hit      = cache_valid && (key == cache_key);
    assign rcon_cur = RCON[rnd];
    assign inv_key  = inv_key_step(rk_q, rcon_cur);

    key_expansion u_kexp (
        .key_in  (rk_q),
        .rcon    (rcon_cur),
        .key_out (fwd_key)
    );

    aes_inv_round u_round (
        .state_in  (state_q),
        .round_key (rk_q),
        .last      (st == ST_FINAL),
        .state_out (round_out)
    );

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            st <= ST_IDLE;
        end else begin
            st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = st;
        unique case (st)
            ST_IDLE:  if (in_valid) nxt_st = hit ? ST_ADDK : ST_KEXP;
            ST_KEXP:  if (rnd == NUM_ROUNDS) nxt_st = ST_ADDK;
            ST_ADDK:  nxt_st = ST_ROUND;
            ST_ROUND: if (rnd == 4'd1) nxt_st = ST_FINAL;
            ST_FINAL: nxt_st = ST_DONE;
            ST_DONE:  if (out_ready) nxt_st = ST_IDLE;
            default:  nxt_st = ST_IDLE;
        endcase
    end

    // rnd tracks the index of the key currently in rk_q's next step:
    // counts 1..10 while expanding forward, then 10 down to 1 while unwinding.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            rnd         <= '0;
            state_q     <= '0;
            rk_q        <= '0;
            key_q       <= '0;
            cache_key   <= '0;
            cache_k10   <= '0;
            cache_valid <= 1'b0;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= data_in;
                        key_q   <= key;
                        if (hit) begin
                            rk_q <= cache_k10;
                            rnd  <= NUM_ROUNDS;
                        end else begin
                            rk_q <= key;
                            rnd  <= 4'd1;
                        end
                    end
                end
                ST_KEXP: begin
                    rk_q <= fwd_key;
                    if (rnd == NUM_ROUNDS) begin
                        cache_k10   <= fwd_key;
                        cache_key   <= key_q;
                        cache_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ST_ADDK: begin
                    state_q <= state_q ^ rk_q;
                    rk_q    <= inv_key;
                    rnd     <= NUM_ROUNDS - 4'd1;
                end
                ST_ROUND: begin
                    state_q <= round_out;
                    rk_q    <= inv_key;
                    rnd     <= rnd - 4'd1;
                end
                ST_FINAL: begin
                    state_q <= round_out;
                end
                ST_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (st == ST_IDLE);
    assign out_valid = (st == ST_DONE);
    assign busy      = (st != ST_IDLE);
    assign plaintext = out_valid ? state_q : '0;

endmodule
